// File: rtl/aes_enc_scheduler.sv
// rtl/aes_enc_scheduler.sv - round-robin job scheduler for a shared multicycle AES-128 encrypt core
module aes_enc_scheduler #(
    parameter int SETTLE_CYCLES = 4,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [127:0]     req0_data,
    input  logic [127:0]     req0_key,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [127:0]     req1_data,
    input  logic [127:0]     req1_key,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [127:0]     core_in,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [127:0]     rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_src,
    output logic             busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              grant;
    logic              accept;
    logic              capture;
    logic [TAG_W-1:0]  tag_q;
    logic              src_q;

    // Round-robin grant: a lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        capture    = (state == SETTLE) && (cnt == '0);
    end

    // Next-state logic for IDLE -> SETTLE -> RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETTLE;
            SETTLE:  if (cnt == '0) state_next = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; busy is registered alongside it so it never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Settle counter and arbitration history; last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            cnt        <= CNT_INIT;
            last_grant <= grant;
        end else if ((state == SETTLE) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Job capture onto the core, then ciphertext capture into the response holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_in   <= '0;
            core_key  <= '0;
            tag_q     <= '0;
            src_q     <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_src   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept) begin
                core_in  <= grant ? req1_data : req0_data;
                core_key <= grant ? req1_key  : req0_key;
                tag_q    <= grant ? req1_tag  : req0_tag;
                src_q    <= grant;
            end
            if (capture) begin
                rsp_data  <= core_out;
                rsp_tag   <= tag_q;
                rsp_src   <= src_q;
                rsp_valid <= 1'b1;
            end else if ((state == RESP) && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// tb/tb_aes_enc_scheduler.sv - directed-vector bench for aes_enc_scheduler
module tb_aes_enc_scheduler;

    localparam int TAG_W = 4;

    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT with SETTLE_CYCLES=4
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0]     req0_data, req0_key, req1_data, req1_key;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [127:0]     core_in, core_key, core_out, rsp_data;
    logic             rsp_valid, rsp_ready, rsp_src, busy;
    logic [TAG_W-1:0] rsp_tag;

    // DUT with SETTLE_CYCLES=1
    logic             b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [127:0]     b_req0_data, b_req0_key, b_req1_data, b_req1_key;
    logic [TAG_W-1:0] b_req0_tag, b_req1_tag;
    logic [127:0]     b_core_in, b_core_key, b_core_out, b_rsp_data;
    logic             b_rsp_valid, b_rsp_ready, b_rsp_src, b_busy;
    logic [TAG_W-1:0] b_rsp_tag;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Stand-in for the encrypt core: known FIPS-197 answers, a scramble otherwise.
    function automatic logic [127:0] core_model(input logic [127:0] pt, input logic [127:0] key);
        if (pt == P_C1 && key == K_C1) return C_C1;
        if (pt == P_B && key == K_B) return C_B;
        return pt ^ {key[63:0], key[127:64]};
    endfunction

    always_comb core_out   = core_model(core_in, core_key);
    always_comb b_core_out = core_model(b_core_in, b_core_key);

    aes_enc_scheduler #(.SETTLE_CYCLES(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_key(req0_key), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_key(req1_key), .req1_tag(req1_tag),
        .core_in(core_in), .core_key(core_key), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_src(rsp_src), .busy(busy)
    );

    aes_enc_scheduler #(.SETTLE_CYCLES(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_data(b_req0_data),
        .req0_key(b_req0_key), .req0_tag(b_req0_tag),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_data(b_req1_data),
        .req1_key(b_req1_key), .req1_tag(b_req1_tag),
        .core_in(b_core_in), .core_key(b_core_key), .core_out(b_core_out),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_tag(b_rsp_tag), .rsp_src(b_rsp_src), .busy(b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready(input logic sel, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (sel ? (b_req0_ready || b_req1_ready) : (req0_ready || req1_ready)) ok = 1'b1;
            else step();
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL wait_ready dut%0d: no ready within 20 cycles", sel);
        end
    endtask

    task automatic wait_rsp(input logic sel, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (sel ? b_rsp_valid : rsp_valid) ok = 1'b1;
            else step();
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL wait_rsp dut%0d: no rsp_valid within 20 cycles", sel);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({busy, rsp_valid, b_busy, b_rsp_valid} !== 4'b0) begin
            nerr++;
            $display("FAIL reset_flags got %b want 0000", {busy, rsp_valid, b_busy, b_rsp_valid});
        end
        rst = 1'b0;
        step();
        nvec++;
        if ({core_in, core_key, rsp_data} !== 384'b0) begin
            nerr++;
            $display("FAIL reset_data got %h %h %h want zero", core_in, core_key, rsp_data);
        end
        nvec++;
        if ({rsp_tag, rsp_src, req0_ready, req1_ready} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_misc got %b want 0", {rsp_tag, rsp_src, req0_ready, req1_ready});
        end
    endtask

    task automatic test_round_robin();
        logic ok;
        int acc[4];
        logic exp_src;
        rsp_ready  = 1'b1;
        req0_data  = P_C1; req0_key = K_C1; req0_tag = 4'd1; req0_valid = 1'b1;
        req1_data  = P_B;  req1_key = K_B;  req1_tag = 4'd2; req1_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_src = logic'(j % 2);
            wait_ready(1'b0, ok);
            nvec++;
            if ({req1_ready, req0_ready} !== {exp_src, ~exp_src}) begin
                nerr++;
                $display("FAIL rr_grant job%0d got r1=%b r0=%b want grant %0d", j, req1_ready, req0_ready, exp_src);
            end
            step();
            acc[j] = cyc;
            if (j == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            wait_rsp(1'b0, ok);
            nvec++;
            if (cyc - acc[j] != 4) begin
                nerr++;
                $display("FAIL rr_latency job%0d got %0d want 4", j, cyc - acc[j]);
            end
            nvec++;
            if ({rsp_data, rsp_tag, rsp_src} !== {(exp_src ? C_B : C_C1), (exp_src ? 4'd2 : 4'd1), exp_src}) begin
                nerr++;
                $display("FAIL rr_rsp job%0d got %h/%h/%b want src %0d", j, rsp_data, rsp_tag, rsp_src, exp_src);
            end
            if (j > 0) begin
                nvec++;
                if (acc[j] - acc[j-1] != 6) begin
                    nerr++;
                    $display("FAIL rr_interval job%0d got %0d want 6", j, acc[j] - acc[j-1]);
                end
            end
            step();
        end
    endtask

    task automatic test_fips_c1();
        logic ok;
        int a;
        rsp_ready  = 1'b0;
        req0_data  = P_C1; req0_key = K_C1; req0_tag = 4'd3; req0_valid = 1'b1;
        #1;
        nvec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            nerr++;
            $display("FAIL c1_ready got %b want 10", {req0_ready, req1_ready});
        end
        step();
        a = cyc;
        req0_valid = 1'b0;
        nvec++;
        if ({core_in, core_key, busy} !== {P_C1, K_C1, 1'b1}) begin
            nerr++;
            $display("FAIL c1_core got %h %h busy=%b want %h %h busy=1", core_in, core_key, busy, P_C1, K_C1);
        end
        wait_rsp(1'b0, ok);
        nvec++;
        if (cyc - a != 4) begin
            nerr++;
            $display("FAIL c1_latency got %0d want 4", cyc - a);
        end
        nvec++;
        if ({rsp_data, rsp_tag, rsp_src} !== {C_C1, 4'd3, 1'b0}) begin
            nerr++;
            $display("FAIL c1_rsp got %h tag %h src %b want %h tag 3 src 0", rsp_data, rsp_tag, rsp_src, C_C1);
        end
        rsp_ready = 1'b1;
        step();
        nvec++;
        if ({rsp_valid, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL c1_done got valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        rsp_ready  = 1'b0;
        req1_data  = P_B; req1_key = K_B; req1_tag = 4'd5; req1_valid = 1'b1;
        wait_ready(1'b0, ok);
        step();
        req1_valid = 1'b0;
        wait_rsp(1'b0, ok);
        req0_data  = P_C1; req0_key = K_C1; req0_tag = 4'd4;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            nvec++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                nerr++;
                $display("FAIL bp_ready cycle%0d got %b want 00", i, {req0_ready, req1_ready});
            end
            nvec++;
            if ({rsp_data, rsp_tag, rsp_src, rsp_valid, busy} !== {C_B, 4'd5, 1'b1, 1'b1, 1'b1}) begin
                nerr++;
                $display("FAIL bp_hold cycle%0d got %h/%h/%b v=%b busy=%b", i, rsp_data, rsp_tag, rsp_src, rsp_valid, busy);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        nvec++;
        if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0010) begin
            nerr++;
            $display("FAIL bp_release got v=%b busy=%b r0=%b r1=%b want 0 0 1 0", rsp_valid, busy, req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(1'b0, ok);
        nvec++;
        if ({rsp_data, rsp_tag, rsp_src} !== {C_C1, 4'd4, 1'b0}) begin
            nerr++;
            $display("FAIL bp_next got %h/%h/%b want %h/4/0", rsp_data, rsp_tag, rsp_src, C_C1);
        end
        step();
    endtask

    task automatic test_resp_pulse();
        logic ok;
        logic seen;
        rsp_ready  = 1'b0;
        req1_data  = P_B; req1_key = K_B; req1_tag = 4'd6; req1_valid = 1'b1;
        wait_ready(1'b0, ok);
        step();
        req1_valid = 1'b0;
        wait_rsp(1'b0, ok);
        step();
        req0_valid = 1'b1;
        #1;
        nvec++;
        if (req0_ready !== 1'b0) begin
            nerr++;
            $display("FAIL pulse_ready got %b want 0", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        nvec++;
        if ({busy, rsp_valid, rsp_src, rsp_tag} !== {1'b1, 1'b1, 1'b1, 4'd6}) begin
            nerr++;
            $display("FAIL pulse_hold got busy=%b v=%b src=%b tag=%h", busy, rsp_valid, rsp_src, rsp_tag);
        end
        rsp_ready = 1'b1;
        step();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid || busy) seen = 1'b1;
            step();
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL pulse_extra got activity=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic seen;
        rsp_ready  = 1'b1;
        req0_data  = P_C1; req0_key = K_C1; req0_tag = 4'd7; req0_valid = 1'b1;
        wait_ready(1'b0, ok);
        step();
        req0_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({busy, rsp_valid, rsp_tag, rsp_src} !== 7'b0) begin
            nerr++;
            $display("FAIL rstmid_flags got busy=%b v=%b tag=%h src=%b want 0", busy, rsp_valid, rsp_tag, rsp_src);
        end
        nvec++;
        if ({core_in, core_key, rsp_data} !== 384'b0) begin
            nerr++;
            $display("FAIL rstmid_data got %h %h %h want zero", core_in, core_key, rsp_data);
        end
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_norsp got rsp seen=%b want 0", seen);
        end
        req0_valid = 1'b1;
        req1_data  = P_B; req1_key = K_B; req1_tag = 4'd8; req1_valid = 1'b1;
        #1;
        nvec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            nerr++;
            $display("FAIL rstmid_grant got %b want 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(1'b0, ok);
        nvec++;
        if ({rsp_data, rsp_tag, rsp_src} !== {C_C1, 4'd7, 1'b0}) begin
            nerr++;
            $display("FAIL rstmid_rsp got %h/%h/%b want %h/7/0", rsp_data, rsp_tag, rsp_src, C_C1);
        end
        step();
    endtask

    task automatic test_settle1();
        logic ok;
        int acc[3];
        b_rsp_ready  = 1'b1;
        b_req1_data  = P_B; b_req1_key = K_B; b_req1_tag = 4'd9; b_req1_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_ready(1'b1, ok);
            step();
            acc[j] = cyc;
            if (j == 2) b_req1_valid = 1'b0;
            wait_rsp(1'b1, ok);
            if (j == 0) begin
                nvec++;
                if (cyc - acc[0] != 1) begin
                    nerr++;
                    $display("FAIL s1_latency got %0d want 1", cyc - acc[0]);
                end
            end else begin
                nvec++;
                if (acc[j] - acc[j-1] != 3) begin
                    nerr++;
                    $display("FAIL s1_interval job%0d got %0d want 3", j, acc[j] - acc[j-1]);
                end
            end
            nvec++;
            if ({b_rsp_data, b_rsp_tag, b_rsp_src} !== {C_B, 4'd9, 1'b1}) begin
                nerr++;
                $display("FAIL s1_rsp job%0d got %h/%h/%b want %h/9/1", j, b_rsp_data, b_rsp_tag, b_rsp_src, C_B);
            end
            step();
        end
    endtask

    initial begin
        req0_valid = 1'b0; req0_data = '0; req0_key = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_data = '0; req1_key = '0; req1_tag = '0;
        rsp_ready  = 1'b0;
        b_req0_valid = 1'b0; b_req0_data = '0; b_req0_key = '0; b_req0_tag = '0;
        b_req1_valid = 1'b0; b_req1_data = '0; b_req1_key = '0; b_req1_tag = '0;
        b_rsp_ready  = 1'b0;
        #1;
        test_reset();
        test_round_robin();
        test_fips_c1();
        test_backpressure();
        test_resp_pulse();
        test_reset_mid();
        test_settle1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/aes_enc_scheduler.md
Name: aes_enc_scheduler

Overview:
- Sequences the shared combinational AES-128 encrypt datapath and arbitrates it between two requesters.
- Accepts a plaintext/key/tag job from either requester over a valid/ready handshake, using round-robin arbitration.
- Drives the registered job onto the core and holds it stable for a fixed settle window, so the core is timed as a multicycle path.
- Captures the ciphertext and returns it on a single valid/ready response channel.

Parameters:
- SETTLE_CYCLES, 4, number of clocks core inputs are held before ciphertext is captured; must be ≥1.
- TAG_W, 4, width of the requester transaction tag.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- req0_valid  input  1  requester 0 job valid.
- req0_ready  output  1  requester 0 job accepted this cycle.
- req0_data  input  128  requester 0 plaintext.
- req0_key  input  128  requester 0 cipher key.
- req0_tag  input  TAG_W  requester 0 tag.
- req1_valid / req1_ready / req1_data / req1_key / req1_tag  same as requester 0, for requester 1.
- core_in  output  128  plaintext to encrypt core (registered).
- core_key  output  128  key to encrypt core (registered).
- core_out  input  128  ciphertext from encrypt core.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  128  captured ciphertext.
- rsp_tag  output  TAG_W  tag of the completed job.
- rsp_src  output  1  requester index (0/1) of the completed job.
- busy  output  1  high in SETTLE or RESP.

Behaviour:
- Reset values (async on rst high):
  - state=IDLE, cnt=0, last_grant=1, so requester 0 wins first.
  - core_in, core_key, rsp_data, rsp_tag, rsp_src, rsp_valid, busy all 0.
- Reset mid-operation: the in-flight job is discarded. No response is ever produced for it.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - grant = the only valid requester. If both are valid, grant = requester != last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. Ready is combinational from valid; at most one ready is high per cycle.
  - On a handshake edge:
    - Register data→core_in, key→core_key, tag, and src.
    - last_grant←N; cnt←SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - If cnt≠0, decrement cnt.
  - If cnt==0: rsp_data←core_out, rsp_tag/rsp_src←stored values, rsp_valid←1, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On an edge with rsp_valid&&rsp_ready: rsp_valid←0, go to IDLE.
- Latency: job accepted at edge T → ciphertext captured and rsp_valid high after edge T+SETTLE_CYCLES.
- Throughput: with rsp_ready held high, one job per SETTLE_CYCLES+2 clocks.
- Hold rules:
  - core_in/core_key change only at an accept edge; they hold their value through SETTLE, RESP and IDLE.
  - No ready is asserted outside IDLE, including while rsp is back-pressured.
- busy = (state≠IDLE), registered with state.
- rsp_valid never depends combinationally on rsp_ready.
- A requester may drop valid without a handshake; nothing is accepted in that case.
- Simultaneous events: both valid in IDLE → exactly one grant per round-robin. The loser keeps waiting and wins the next IDLE cycle if still valid.

Test Plan:
- FIPS-197 C.1 vector on req0, tag=3:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Expected: rsp_valid exactly 4 clocks after accept; rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a; rsp_tag=3; rsp_src=0.
- Both requesters continuously valid, 4 jobs; req1 uses FIPS-197 B (key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734):
  - Expected: grants in order 0,1,0,1.
  - Expected: req1 responses = 3925841d02dc09fbdc118597196a0b32.
  - Expected: a new accept every 6 clocks with rsp_ready=1.
- rsp_ready held low 10 clocks after rsp_valid:
  - Expected: rsp_data/tag/src stable, busy=1, both req ready=0.
  - Expected: on rsp_ready=1, one-cycle handshake, then IDLE and the next grant.
- rst pulsed during SETTLE (cnt=2):
  - Expected: all outputs 0 immediately (async), no response ever emitted.
  - Expected: with both valid afterwards, first grant goes to req0.
- SETTLE_CYCLES=1 build, single req1 job:
  - Expected: rsp_valid asserted 1 clock after accept edge, correct ciphertext.
  - Expected: back-to-back jobs every 3 clocks.
- req0_valid pulsed for one cycle while the block is in RESP:
  - Expected: req0_ready stays 0, no job accepted, no extra response.
